// File: rtl/cfu_simd_pkg.sv
// Shared types and constants for the SIMD MAC custom function unit.
// Opcode and FSM encodings, lane geometry and the dot-sum width helper.
package cfu_simd_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;

  typedef enum logic [6:0] {
    CLEAR      = 7'd0,
    SET_OFFSET = 7'd1,
    MAC4       = 7'd2,
    READ       = 7'd3,
    READ_CLEAR = 7'd4
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // (activation + offset) is OFFSET_W+1 bits, times an int8 weight, plus 2 guard bits for 4 lanes
  function automatic int dot_width(input int offset_w);
    return offset_w + LANE_W + 1 + 2;
  endfunction

endpackage

// File: rtl/cfu_dot4.sv
// Four-lane int8 dot product with a signed input offset, pipelined over STAGES registers.
// STAGES=0 is purely combinational; the first stage registers the lane products.
module cfu_dot4
  import cfu_simd_pkg::*;
#(
  parameter int OFFSET_W = 9,
  parameter int STAGES   = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [LANES*LANE_W-1:0]              a,
  input  logic [LANES*LANE_W-1:0]              w,
  input  logic signed [OFFSET_W-1:0]           offset,
  output logic signed [dot_width(OFFSET_W)-1:0] dot
);

  localparam int PROD_W = OFFSET_W + LANE_W + 1;
  localparam int DOT_W  = dot_width(OFFSET_W);

  logic signed [OFFSET_W:0]   a_off [LANES];
  logic signed [PROD_W-1:0]   prod  [LANES];

  // Offsets are assumed at least as wide as a lane, as in TFLM (OFFSET_W >= 8)
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      a_off[i] = (OFFSET_W+1)'($signed(a[i*LANE_W +: LANE_W])) + (OFFSET_W+1)'(offset);
      prod[i]  = PROD_W'(a_off[i]) * PROD_W'($signed(w[i*LANE_W +: LANE_W]));
    end
  end

  generate
    if (STAGES == 0) begin : g_comb
      always_comb begin
        dot = '0;
        for (int i = 0; i < LANES; i++) dot = dot + DOT_W'(prod[i]);
      end
    end else begin : g_pipe
      logic signed [PROD_W-1:0] prod_q [LANES];
      logic signed [DOT_W-1:0]  sum_s;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
        end else begin
          for (int i = 0; i < LANES; i++) prod_q[i] <= prod[i];
        end
      end

      always_comb begin
        sum_s = '0;
        for (int i = 0; i < LANES; i++) sum_s = sum_s + DOT_W'(prod_q[i]);
      end

      if (STAGES == 1) begin : g_one
        assign dot = sum_s;
      end else begin : g_dly
        logic signed [DOT_W-1:0] dly [STAGES-1];
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            for (int k = 0; k < STAGES-1; k++) dly[k] <= '0;
          end else begin
            dly[0] <= sum_s;
            for (int k = 1; k < STAGES-1; k++) dly[k] <= dly[k-1];
          end
        end
        assign dot = dly[STAGES-2];
      end
    end
  endgenerate

endmodule

// File: rtl/cfu_simd_mac.sv
// CFU cmd/rsp wrapper around NUM_ACC signed accumulators fed by a pipelined int8 dot product.
// Define CFU_SIMD_MAC_SAT_EN for saturating accumulation with a sticky clip flag.
module cfu_simd_mac
  import cfu_simd_pkg::*;
#(
  parameter int NUM_ACC     = 4,
  parameter int ACC_W       = 32,
  parameter int OFFSET_W    = 9,
  parameter int MAC_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0,
  output state_e      state_dbg
);

  localparam int DOT_W = dot_width(OFFSET_W);
  localparam int CNT_W = $clog2(MAC_LATENCY) + 1;

  state_e                      state, state_nx;
  logic [CNT_W-1:0]            cnt;
  logic [2:0]                  idx, idx_q, sel_idx;
  logic                        idx_ok;
  op_e                         op;
  logic signed [ACC_W-1:0]     acc [NUM_ACC];
  logic signed [OFFSET_W-1:0]  offset;
  logic [31:0]                 rsp_data, rsp_nx, rd_val;
  logic                        rsp_load, acc_we, offset_we;
  logic signed [ACC_W-1:0]     acc_wdata, acc_sel, mac_new;
  logic signed [DOT_W-1:0]     dot;

  // Handshake: a command transfers on a cycle with cmd_valid && cmd_ready, a response on
  // rsp_valid && rsp_ready; rsp_payload stays fixed from RESP entry until that transfer.
  assign cmd_ready             = (state == IDLE);
  assign rsp_valid             = (state == RESP);
  assign rsp_payload_outputs_0 = rsp_data;
  assign state_dbg             = state;

  assign op      = op_e'(cmd_payload_function_id[9:3]);
  assign idx     = cmd_payload_function_id[2:0];
  assign idx_ok  = (int'(idx) < NUM_ACC);
  assign sel_idx = (state == EXEC) ? idx_q : idx;

  cfu_dot4 #(.OFFSET_W(OFFSET_W), .STAGES(MAC_LATENCY-1)) u_dot4 (
    .clk    (clk),
    .reset  (reset),
    .a      (cmd_payload_inputs_0),
    .w      (cmd_payload_inputs_1),
    .offset (offset),
    .dot    (dot)
  );

  always_comb begin
    acc_sel = '0;
    for (int i = 0; i < NUM_ACC; i++) if (sel_idx == 3'(i)) acc_sel = acc[i];
  end

`ifdef CFU_SIMD_MAC_SAT_EN
  localparam int SUM_W = ((ACC_W > DOT_W) ? ACC_W : DOT_W) + 1;
  logic signed [SUM_W-1:0] mac_sum;
  logic                    mac_clip, sat_flag, sat_set, sat_clr;
  assign mac_sum  = SUM_W'(acc_sel) + SUM_W'(dot);
  // Clip whenever the bits above the ACC_W sign bit disagree with it
  assign mac_clip = !((&mac_sum[SUM_W-1:ACC_W-1]) || !(|mac_sum[SUM_W-1:ACC_W-1]));
  assign mac_new  = mac_clip ? {mac_sum[SUM_W-1], {(ACC_W-1){~mac_sum[SUM_W-1]}}}
                             : mac_sum[ACC_W-1:0];
`else
  assign mac_new  = acc_sel + ACC_W'(dot);
`endif

  always_comb begin
    rd_val = 32'(acc_sel);
`ifdef CFU_SIMD_MAC_SAT_EN
    if (ACC_W < 32) rd_val[31] = sat_flag;
`endif
  end

  always_comb begin
    state_nx  = state;
    rsp_nx    = '0;
    rsp_load  = 1'b0;
    acc_we    = 1'b0;
    acc_wdata = '0;
    offset_we = 1'b0;
`ifdef CFU_SIMD_MAC_SAT_EN
    sat_set   = 1'b0;
    sat_clr   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nx = RESP;
          rsp_load = 1'b1;
          if (idx_ok) begin
            case (op)
              CLEAR: begin
                acc_we = 1'b1;
`ifdef CFU_SIMD_MAC_SAT_EN
                sat_clr = 1'b1;
`endif
              end
              SET_OFFSET: begin
                offset_we = 1'b1;
                rsp_nx    = 32'(offset);
              end
              MAC4: begin
                if (MAC_LATENCY > 1) begin
                  state_nx = EXEC;
                  rsp_load = 1'b0;
                end else begin
                  acc_we    = 1'b1;
                  acc_wdata = mac_new;
                  rsp_nx    = 32'(mac_new);
`ifdef CFU_SIMD_MAC_SAT_EN
                  sat_set   = mac_clip;
`endif
                end
              end
              READ:       rsp_nx = rd_val;
              READ_CLEAR: begin
                acc_we = 1'b1;
                rsp_nx = 32'(acc_sel);
              end
              default: ;
            endcase
          end
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          state_nx  = RESP;
          rsp_load  = 1'b1;
          acc_we    = 1'b1;
          acc_wdata = mac_new;
          rsp_nx    = 32'(mac_new);
`ifdef CFU_SIMD_MAC_SAT_EN
          sat_set   = mac_clip;
`endif
        end
      end
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      idx_q    <= '0;
      offset   <= '0;
      rsp_data <= '0;
      for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        idx_q <= idx;
        cnt   <= CNT_W'(MAC_LATENCY - 2);
      end else if (state == EXEC) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (rsp_load)  rsp_data <= rsp_nx;
      if (offset_we) offset   <= cmd_payload_inputs_0[OFFSET_W-1:0];
      for (int i = 0; i < NUM_ACC; i++) begin
        if (acc_we && sel_idx == 3'(i)) acc[i] <= acc_wdata;
      end
    end
  end

`ifdef CFU_SIMD_MAC_SAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        sat_flag <= 1'b0;
    else if (sat_clr) sat_flag <= 1'b0;
    else if (sat_set) sat_flag <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_cfu_simd_mac.sv
// Directed bench for cfu_simd_mac: vector table plus backpressure, reset and ACC_W=16 sequences.
// A second instance with ACC_W=16 shares the stimulus and is checked only in the width test.
module tb_cfu_simd_mac;
  import cfu_simd_pkg::*;

  logic        clk, reset;
  logic        cmd_valid, rsp_ready;
  logic [9:0]  fid;
  logic [31:0] in0, in1;
  logic        cmd_ready, rsp_valid, cmd_ready16, rsp_valid16;
  logic [31:0] rsp_payload, rsp16;
  state_e      st, st16;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[$];

  cfu_simd_mac dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_payload_function_id(fid), .cmd_payload_inputs_0(in0), .cmd_payload_inputs_1(in1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(rsp_payload),
    .state_dbg(st)
  );

  cfu_simd_mac #(.ACC_W(16)) dut16 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready16),
    .cmd_payload_function_id(fid), .cmd_payload_inputs_0(in0), .cmd_payload_inputs_1(in1),
    .rsp_valid(rsp_valid16), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(rsp16),
    .state_dbg(st16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one command, wait for its response and take it with rsp_ready held high.
  task automatic do_cmd(input logic [6:0] op, input logic [2:0] idx, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] r, output logic [31:0] r16,
                        output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    fid = {op, idx};
    in0 = a;
    in1 = b;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r   = rsp_payload;
    r16 = rsp16;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  logic [31:0] r, r16;
  int          lat;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; fid = '0; in0 = '0; in1 = '0;

    vecs.push_back('{MAC4,       3'd0, 32'h01020304, 32'h01010101, 32'h0000000A, 2});
    vecs.push_back('{MAC4,       3'd0, 32'h01020304, 32'hFFFFFFFF, 32'h00000000, 2});
    vecs.push_back('{SET_OFFSET, 3'd0, 32'h00000080, 32'h00000000, 32'h00000000, 1});
    vecs.push_back('{MAC4,       3'd1, 32'h80808080, 32'h01010101, 32'h00000000, 2});
    vecs.push_back('{READ,       3'd1, 32'h00000000, 32'h00000000, 32'h00000000, 1});
    vecs.push_back('{SET_OFFSET, 3'd0, 32'h00000000, 32'h00000000, 32'h00000080, 1});
    vecs.push_back('{MAC4,       3'd2, 32'h7FFF0102, 32'h02030405, 32'h00000109, 2});
    vecs.push_back('{SET_OFFSET, 3'd0, 32'h000001FF, 32'h00000000, 32'h00000000, 1});
    vecs.push_back('{MAC4,       3'd2, 32'h00000000, 32'h01020304, 32'h000000FF, 2});
    vecs.push_back('{SET_OFFSET, 3'd0, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1});
    vecs.push_back('{READ_CLEAR, 3'd2, 32'h00000000, 32'h00000000, 32'h000000FF, 1});
    vecs.push_back('{READ,       3'd2, 32'h00000000, 32'h00000000, 32'h00000000, 1});
    vecs.push_back('{MAC4,       3'd3, 32'h80808080, 32'h7F7F7F7F, 32'hFFFF0200, 2});
    vecs.push_back('{CLEAR,      3'd3, 32'h00000000, 32'h00000000, 32'h00000000, 1});
    vecs.push_back('{READ,       3'd3, 32'h00000000, 32'h00000000, 32'h00000000, 1});
    vecs.push_back('{MAC4,       3'd0, 32'h00000003, 32'h00000004, 32'h0000000C, 2});
    vecs.push_back('{MAC4,       3'd7, 32'h01010101, 32'h01010101, 32'h00000000, 1});
    vecs.push_back('{7'd9,       3'd0, 32'h01010101, 32'h01010101, 32'h00000000, 1});
    vecs.push_back('{READ,       3'd0, 32'h00000000, 32'h00000000, 32'h0000000C, 1});
    vecs.push_back('{READ,       3'd4, 32'h00000000, 32'h00000000, 32'h00000000, 1});

    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_payload", rsp_payload, 32'd0);
    check("rst_state", 32'(st), 32'(IDLE));
    reset = 1'b0;

    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].exp);
      do_cmd(vecs[i].op, vecs[i].idx, vecs[i].a, vecs[i].b, r, r16, lat);
      check($sformatf("vec%0d_rsp", i), r, exp_q.pop_front());
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
    end

    // ACC_W=16: four lanes of (-128)*(-128) sum to 65536
    do_cmd(CLEAR, 3'd0, 32'h0, 32'h0, r, r16, lat);
    do_cmd(MAC4, 3'd0, 32'h80808080, 32'h80808080, r, r16, lat);
    check("w32_mac", r, 32'h00010000);
`ifdef CFU_SIMD_MAC_SAT_EN
    check("w16_sat_mac", r16, 32'h00007FFF);
    do_cmd(READ, 3'd0, 32'h0, 32'h0, r, r16, lat);
    check("w16_sat_flag", 32'(r16[31]), 32'd1);
`else
    check("w16_wrap_mac", r16, 32'h00000000);
    do_cmd(READ, 3'd0, 32'h0, 32'h0, r, r16, lat);
    check("w16_wrap_read", r16, 32'h00000000);
`endif
    check("w32_read", r, 32'h00010000);

    // Backpressure: hold the response for three cycles, with an ignored command pulse
    @(negedge clk);
    cmd_valid = 1'b1; fid = {MAC4, 3'd1}; in0 = 32'h01020304; in1 = 32'h01010101;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_lat", 32'(lat), 32'd2);
    check("bp_rsp", rsp_payload, 32'h0000000A);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        cmd_valid = 1'b1;
        fid = {CLEAR, 3'd1};
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      check("bp_hold", rsp_payload, 32'h0000000A);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_release_ready", 32'(cmd_ready), 32'd1);
    check("bp_release_valid", 32'(rsp_valid), 32'd0);
    do_cmd(READ, 3'd1, 32'h0, 32'h0, r, r16, lat);
    check("bp_pulse_ignored", r, 32'h0000000A);

    // Reset while a MAC4 is in EXEC
    do_cmd(SET_OFFSET, 3'd0, 32'h00000005, 32'h0, r, r16, lat);
    @(negedge clk);
    cmd_valid = 1'b1; fid = {MAC4, 3'd0}; in0 = 32'h01010101; in1 = 32'h01010101;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("exec_state", 32'(st), 32'(EXEC));
    #1 reset = 1'b1;
    #1;
    check("rst_exec_valid", 32'(rsp_valid), 32'd0);
    check("rst_exec_state", 32'(st), 32'(IDLE));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_exec_ready", 32'(cmd_ready), 32'd1);
    check("rst_exec_novalid", 32'(rsp_valid), 32'd0);
    do_cmd(READ, 3'd0, 32'h0, 32'h0, r, r16, lat);
    check("rst_exec_acc0", r, 32'h0);
    do_cmd(READ, 3'd1, 32'h0, 32'h0, r, r16, lat);
    check("rst_exec_acc1", r, 32'h0);
    do_cmd(SET_OFFSET, 3'd0, 32'h0, 32'h0, r, r16, lat);
    check("rst_exec_offset", r, 32'h0);

    // Reset while a response is waiting in RESP
    @(negedge clk);
    cmd_valid = 1'b1; fid = {MAC4, 3'd2}; in0 = 32'h01020304; in1 = 32'h01010101;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("resp_before_rst", rsp_payload, 32'h0000000A);
    #1 reset = 1'b1;
    #1;
    check("rst_resp_valid", 32'(rsp_valid), 32'd0);
    check("rst_resp_payload", rsp_payload, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    do_cmd(READ, 3'd2, 32'h0, 32'h0, r, r16, lat);
    check("rst_resp_acc2", r, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cfu_simd_mac.md
Name: cfu_simd_mac

Overview:
- Parametrised successor to the single-function conv1d CFU wrapper.
- Implements the CPU custom-function-unit cmd/rsp handshake around NUM_ACC independent signed accumulators.
- Each MAC command computes a 4-lane int8 dot product with a programmable input offset, as in TFLM quantised conv.
- Supports multi-cycle pipelined MAC latency and a proper busy/response FSM, so the CPU never samples a stale result.

Parameters:
- NUM_ACC, 4, number of accumulators; legal range 1..8; selected by funct3.
- ACC_W, 32, accumulator width in bits; legal range 16..32.
- OFFSET_W, 9, signed input-offset register width.
- MAC_LATENCY, 2, cycles from MAC command accept to rsp_valid; legal range >=1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  unit can accept a command
- cmd_payload_function_id  in  10  [9:3] funct7 = opcode, [2:0] funct3 = accumulator index
- cmd_payload_inputs_0  in  32  operand A (4 packed int8 activations / offset value)
- cmd_payload_inputs_1  in  32  operand B (4 packed int8 weights)
- rsp_valid  out  1  response available
- rsp_ready  in  1  CPU takes response
- rsp_payload_outputs_0  out  32  result

Behaviour:
- Reset: one clock domain, clk; reset asynchronous, active-high. On assertion:
  - FSM goes to IDLE.
  - rsp_valid=0, rsp_payload_outputs_0=0.
  - All accumulators and the offset are cleared to 0.
  - Any in-flight MAC is discarded, including when reset arrives mid-EXEC or mid-RESP.
- Handshake:
  - cmd_ready = (state==IDLE).
  - A command is accepted at cycle T when cmd_valid && cmd_ready.
  - A response completes when rsp_valid && rsp_ready.
  - rsp_payload is registered and held stable while rsp_valid && !rsp_ready.
- FSM states and transitions:
  - IDLE -> EXEC on accept of MAC4 when MAC_LATENCY>1.
  - IDLE -> RESP on accept of any other opcode, or of MAC4 when MAC_LATENCY==1.
  - EXEC: down-counter from MAC_LATENCY-2; -> RESP when the counter reaches 0.
  - RESP: rsp_valid=1; -> IDLE on rsp_ready.
  - cmd_ready reasserts the cycle after the response handshake.
- Latency: non-MAC opcodes give rsp_valid at T+1; MAC4 gives rsp_valid at T+MAC_LATENCY.
- Opcodes (funct7), idx = funct3:
  - 0 CLEAR: acc[idx]<=0; rsp 0.
  - 1 SET_OFFSET: offset<=inputs_0[OFFSET_W-1:0]; rsp = previous offset, sign-extended to 32.
  - 2 MAC4: acc[idx] += sum over i=0..3 of (sext(in0[8i+7:8i])+offset)*sext(in1[8i+7:8i]); rsp = updated acc.
  - 3 READ: rsp = acc[idx].
  - 4 READ_CLEAR: rsp = acc[idx]; acc[idx]<=0 in the same update.
  - Other opcodes: no state change; rsp 0.
- Out-of-range index (idx>=NUM_ACC): no state change; rsp 0; the handshake still completes normally.
- Arithmetic:
  - Each product is computed at OFFSET_W+9 bits signed; the dot sum carries 2 extra guard bits.
  - The sum is added into acc at ACC_W+1 bits, then stored at ACC_W bits.
  - Responses are acc sign-extended to 32 bits.
  - Default behaviour (no macro) is two's-complement wrap modulo 2^ACC_W.
- The accumulator update commits in the same cycle RESP is entered; a READ issued after a MAC always sees the updated value.

Optional Feature:
- Macro: CFU_SIMD_MAC_SAT_EN.
- Defined: the MAC4 and accumulator addition saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. A sticky sat flag is set on any clip; READ returns it in bit 31 only when ACC_W<32, and CLEAR resets it.
- Undefined: wrap-around arithmetic; no flag logic is synthesised.

Decomposition:
- Package cfu_simd_pkg contains:
  - op_e enum: CLEAR, SET_OFFSET, MAC4, READ, READ_CLEAR.
  - state_e enum: IDLE, EXEC, RESP.
  - LANES=4 and LANE_W=8 constants.
  - A function computing the dot-sum width from OFFSET_W.
- Sub-module cfu_dot4: a pipelined 4-lane offset dot product with MAC_LATENCY-1 internal register stages. The top level holds the FSM, accumulator bank, offset register and response register.

Test Plan:
- Offset 0, MAC4 idx0 with in0=0x01020304, in1=0x01010101 -> rsp 0x0000000A at T+2. Repeat with in1=0xFFFFFFFF -> rsp 0x00000000 (10-10).
- SET_OFFSET 128 (rsp 0), then MAC4 idx1 with in0=0x80808080, in1=0x01010101 -> rsp 0. Then READ idx1 -> 0; SET_OFFSET 0 -> rsp 0x00000080.
- ACC_W=16, offset 0, MAC4 with in0=in1=0x80808080 (sum 65536):
  - Without macro -> rsp 0x00000000.
  - With CFU_SIMD_MAC_SAT_EN -> rsp 0x00007FFF and READ bit31=1.
- Backpressure: hold rsp_ready=0 for 3 cycles after rsp_valid -> payload stable, cmd_ready=0, a cmd_valid pulse is ignored; rsp_ready=1 -> cmd_ready=1 next cycle.
- Assert reset during EXEC of a MAC4 -> rsp_valid=0 immediately, cmd_ready=1 after release, READ idx0 -> 0.
- idx=7 with NUM_ACC=4, MAC4 -> rsp 0 at T+1, all accumulators unchanged. Opcode 9 -> rsp 0.
